// File: rtl/bsg_util_link_pkg.sv
// Shared types for the util wormhole link endpoints.
// Header layout {len, cord} and the endpoint FSM states.
package bsg_util_link_pkg;

  localparam int cord_width_gp = 4;
  localparam int len_width_gp  = 4;

  typedef struct packed {
    logic [len_width_gp-1:0]  len;
    logic [cord_width_gp-1:0] cord;
  } bsg_util_link_hdr_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } bsg_util_link_state_e;

endpackage

// File: rtl/bsg_util_link_gpio_in_debounce.sv
// Pin synchronizer plus shared debounce counter.
// Ports: clk_i, reset_i, gpio_i (async pins), sampled_o (debounced).
module bsg_util_link_gpio_in_debounce
  import bsg_util_link_pkg::*;
#(
  parameter int width_p           = 32,
  parameter int debounce_cycles_p = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] gpio_i,
  output logic [width_p-1:0] sampled_o
);

  localparam int cw_lp =
    (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;
  localparam logic [cw_lp-1:0] last_lp =
    cw_lp'(debounce_cycles_p - 1);

  logic [width_p-1:0] meta_q, sync_q;
  logic [width_p-1:0] cand_q, sampled_q;
  logic [cw_lp-1:0]   cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      cand_q    <= '0;
      sampled_q <= '0;
      cnt_q     <= '0;
    end else begin
      meta_q <= gpio_i;
      sync_q <= meta_q;
      // any movement on any pin restarts the stability window
      if (cand_q != sync_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q != last_lp) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        sampled_q <= cand_q;
      end
    end
  end

  assign sampled_o = sampled_q;

endmodule

// File: rtl/bsg_util_link_gpio_in.sv
// GPIO input endpoint: reports pin snapshots as wormhole packets.
// Ports: clk_i, reset_i, gpio_i, dest_cord_i, report_req_i,
//   link_i/link_o {v, data, ready_and_rev}, busy_o.
// Optional debounce: define BSG_UTIL_LINK_GPIO_IN_DEBOUNCE_EN.
module bsg_util_link_gpio_in
  import bsg_util_link_pkg::*;
#(
  parameter int flit_width_p      = 8,
  parameter int num_gpio_p        = 32,
  parameter int cord_width_p      = 4,
  parameter int len_width_p       = 4,
  parameter int debounce_cycles_p = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [num_gpio_p-1:0]   gpio_i,
  input  logic [cord_width_p-1:0] dest_cord_i,
  input  logic                    report_req_i,
  input  logic [flit_width_p+1:0] link_i,
  output logic [flit_width_p+1:0] link_o,
  output logic                    busy_o
);

  localparam int payload_flits_lp =
    (num_gpio_p + flit_width_p - 1) / flit_width_p;
  localparam int cnt_w_lp =
    (payload_flits_lp > 1) ? $clog2(payload_flits_lp) : 1;
  localparam int snap_w_lp = payload_flits_lp * flit_width_p;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp =
    cnt_w_lp'(payload_flits_lp - 1);

  logic [num_gpio_p-1:0] sampled_w;

`ifdef BSG_UTIL_LINK_GPIO_IN_DEBOUNCE_EN
  bsg_util_link_gpio_in_debounce #(
    .width_p          (num_gpio_p),
    .debounce_cycles_p(debounce_cycles_p)
  ) deb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .gpio_i   (gpio_i),
    .sampled_o(sampled_w)
  );
`else
  logic [num_gpio_p-1:0] meta_q, sync_q;
  logic unused_deb_w;

  assign unused_deb_w = (debounce_cycles_p == 0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= gpio_i;
      sync_q <= meta_q;
    end
  end

  assign sampled_w = sync_q;
`endif

  // inbound flits are always accepted and dropped
  logic [flit_width_p:0] unused_link_w;
  logic                  ready_w;

  assign unused_link_w = link_i[flit_width_p+1:1];
  assign ready_w       = link_i[0];

  bsg_util_link_state_e    state_q, state_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [num_gpio_p-1:0]   last_q, last_d;
  logic [snap_w_lp-1:0]    snap_q, snap_d;
  logic [cord_width_p-1:0] dest_q, dest_d;
  logic                    pend_q, pend_d;
  logic                    rdy_q;

  logic                    v_w, xfer_w, go_w;
  logic [snap_w_lp-1:0]    snap_ext_w;
  logic [flit_width_p-1:0] hdr_w, flit_w;

  assign v_w    = (state_q != IDLE);
  assign xfer_w = v_w & ready_w;
  assign go_w   = (state_q == IDLE)
                & ((sampled_w != last_q) | pend_q);

  // a request landing on the launch cycle stays pending
  assign pend_d = report_req_i | (pend_q & ~go_w);

  always_comb begin
    snap_ext_w = '0;
    snap_ext_w[num_gpio_p-1:0] = sampled_w;
  end

  always_comb begin
    hdr_w = '0;
    hdr_w[cord_width_p-1:0] = dest_q;
    hdr_w[cord_width_p+:len_width_p] =
      len_width_p'(payload_flits_lp);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    snap_d  = snap_q;
    dest_d  = dest_q;
    unique case (state_q)
      IDLE: begin
        if (go_w) begin
          snap_d  = snap_ext_w;
          last_d  = sampled_w;
          dest_d  = dest_cord_i;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer_w) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer_w) begin
          if (cnt_q == cnt_last_lp) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      snap_q  <= '0;
      dest_q  <= '0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      snap_q  <= snap_d;
      dest_q  <= dest_d;
      pend_q  <= pend_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    flit_w = '0;
    unique case (state_q)
      HDR:     flit_w = hdr_w;
      DATA:    flit_w = snap_q[cnt_q*flit_width_p +: flit_width_p];
      default: flit_w = '0;
    endcase
  end

  assign link_o = {v_w, flit_w, rdy_q};
  assign busy_o = v_w;

endmodule
